// File: rtl/alu_seq_pkg.sv
// Shared types and sizes for the ALU sweep sequencer and its result buffer.
package alu_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int SEL_W   = 4;
    localparam int NUM_OPS = 2 ** SEL_W;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OPS - 1);

    // Sequencer states; ST_ prefix keeps WAIT clear of the wait keyword.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One captured ALU result (25 bits with the default sizes).
    typedef struct packed {
        logic [DATA_W-1:0]   out;
        logic [2*DATA_W-1:0] mul;
        logic                carry;
    } result_t;

    // Build a result entry from the individual ALU outputs.
    function automatic result_t pack_result(
        input logic [DATA_W-1:0]   out,
        input logic [2*DATA_W-1:0] mul,
        input logic                carry
    );
        result_t r;
        r.out   = out;
        r.mul   = mul;
        r.carry = carry;
        return r;
    endfunction

endpackage

// File: rtl/alu_result_buf.sv
// Result register file: one entry per opcode, a valid mask that can be
// cleared in one cycle, and a registered read port with read-before-write
// behaviour on a same-cycle address collision.
module alu_result_buf
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [SEL_W-1:0] waddr,
    input  result_t          wdata,
    input  logic [SEL_W-1:0] raddr,
    output result_t          rdata,
    output logic             rvalid
);

    result_t              mem [NUM_OPS];
    logic [NUM_OPS-1:0]   valid;

    // Data storage: no reset, the valid mask decides whether an entry means anything.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Valid mask: clear-all on a new sweep, set per entry as it is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (we) begin
            valid[waddr] <= 1'b1;
        end
    end

    // Registered read; non-blocking update means a colliding write is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rdata  <= mem[raddr];
            rvalid <= valid[raddr];
        end
    end

endmodule

// File: rtl/alu_sweep_sequencer.sv
// On start, latches an operand pair, steps the ALU opcode through every
// value, waits SETTLE cycles per opcode and captures the ALU results into
// a readable buffer. SETTLE must lie in 1..15.
module alu_sweep_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   a_in,
    input  logic [DATA_W-1:0]   b_in,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [SEL_W-1:0]    alu_sel,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic [2*DATA_W-1:0] alu_mul,
    input  logic                alu_carry,
    input  logic [SEL_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]   rd_out,
    output logic [2*DATA_W-1:0] rd_mul,
    output logic                rd_carry,
    output logic                rd_valid
);

    // Counter reload: WAIT runs SETTLE cycles, counting SETTLE-1 down to 0.
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;

    logic       buf_clr;
    logic       buf_we;
    result_t    buf_wdata;
    result_t    buf_rdata;

    // Sequencer FSM with registered handshake and ALU drive outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        alu_a      <= a_in;
                        alu_b      <= b_in;
                        alu_sel    <= '0;
                        settle_cnt <= SETTLE_LD;
                        busy       <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    // Last opcode ends the sweep; alu_sel holds rather than wrapping.
                    if (alu_sel == LAST_SEL) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        alu_sel    <= alu_sel + 1'b1;
                        settle_cnt <= SETTLE_LD;
                        state      <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here; a new sweep waits for IDLE.
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer control decoded from the current state.
    always_comb begin
        buf_clr   = (state == ST_IDLE) && start;
        buf_we    = (state == ST_CAPTURE);
        buf_wdata = pack_result(alu_out, alu_mul, alu_carry);
    end

    alu_result_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (buf_clr),
        .we     (buf_we),
        .waddr  (alu_sel),
        .wdata  (buf_wdata),
        .raddr  (rd_addr),
        .rdata  (buf_rdata),
        .rvalid (rd_valid)
    );

    assign rd_out   = buf_rdata.out;
    assign rd_mul   = buf_rdata.mul;
    assign rd_carry = buf_rdata.carry;

endmodule

// File: doc/alu_sweep_sequencer.md
# alu_sweep_sequencer

Synthesizable stimulus-and-capture engine that sits on the operand/opcode side of the 8-bit `alu`. On `start` it latches one operand pair and drives it into the ALU. It then steps `select` through all 16 opcodes, waits a programmable settle time per opcode, and captures `out`/`mul`/`carry` into a 16-entry result buffer. A registered read port returns the captured results, so the ALU can be characterised on-chip without a testbench driver.

## Interface
- `DATA_W`, 8: operand and `out` width; `mul` is 2*DATA_W.
- `SEL_W`, 4: opcode width; NUM_OPS = 2**SEL_W = 16.
- `SETTLE`, 2: wait cycles per opcode before capture; legal range 1..15; 0 is illegal.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a sweep; sampled only in IDLE.
- `a_in`, `b_in` input DATA_W: operands, latched in the cycle `start` is accepted.
- `busy` output 1: high in WAIT and CAPTURE.
- `done` output 1: one-cycle pulse in DONE.
- `alu_a`, `alu_b` output DATA_W: registered operands to the ALU.
- `alu_sel` output SEL_W: registered opcode to the ALU.
- `alu_out` input DATA_W, `alu_mul` input 2*DATA_W, `alu_carry` input 1: ALU results.
- `rd_addr` input SEL_W: buffer read index.
- `rd_out` output DATA_W, `rd_mul` output 2*DATA_W, `rd_carry` output 1, `rd_valid` output 1: registered read data.

## Operation
- States: IDLE, WAIT, CAPTURE, DONE.
- IDLE, `start`=1: latch `a_in`→`alu_a` and `b_in`→`alu_b`; `alu_sel`←0; `settle_cnt`←SETTLE-1; clear the valid mask; go to WAIT. With `start`=0, stay in IDLE.
- WAIT: if `settle_cnt`==0, go to CAPTURE; else decrement `settle_cnt`.
- CAPTURE: at the closing edge write {`alu_out`, `alu_mul`, `alu_carry`} to `buf[alu_sel]` and set `valid[alu_sel]`.
  - If `alu_sel`==NUM_OPS-1, go to DONE.
  - Otherwise `alu_sel`+1, reload `settle_cnt`, go to WAIT.
- DONE: `done`=1 for this single cycle; go to IDLE.
- `start` is ignored outside IDLE, including in DONE.
- `alu_a`, `alu_b` and `alu_sel` hold their values after DONE until the next accepted `start`. `alu_sel` never wraps mid-sweep.
- Read port: `rd_*` are registered from `buf[rd_addr]` and `valid[rd_addr]`. Reads are allowed at any time, including mid-sweep.
- Read of the entry being written in the same cycle: the registered read returns the pre-write contents (old data and valid).
- Reset at any time forces the following, asynchronously:
  - state IDLE;
  - `busy`, `done`, `alu_a`, `alu_b`, `alu_sel`, `settle_cnt`, all `rd_*` = 0;
  - the whole valid mask = 0.
  - Buffer data need not be cleared, because `rd_valid` gates it.

## Timing
- Cycle 0 is the cycle in which `start` is accepted in IDLE.
- Opcode k occupies SETTLE+1 cycles:
  - WAIT: cycles 1+k(SETTLE+1) .. k(SETTLE+1)+SETTLE;
  - CAPTURE: cycle (k+1)(SETTLE+1).
- Last capture is at cycle 16(SETTLE+1). `done` is high in cycle 16(SETTLE+1)+1, and the next `start` can be accepted one cycle later.
- With SETTLE=2: captures at cycles 3, 6, …, 48; `done` in cycle 49; IDLE from cycle 50.
- `busy` is high in cycles 1..16(SETTLE+1).
- Read latency: 1 cycle from `rd_addr` to `rd_*`.

## Structure
- Package `alu_seq_pkg` holds:
  - the state enum (IDLE/WAIT/CAPTURE/DONE);
  - DATA_W, SEL_W and NUM_OPS localparams;
  - the result-entry struct {out, mul, carry}.
- Sub-module `alu_result_buf`: a 16×25-bit register file with a write port, a 16-bit valid mask (clear-all input, async reset), and a registered read port.
- The top level contains the FSM, the settle counter and the operand registers.

## Test plan
The bench drives the ALU inputs from a stub model: out = A+B+sel (mod 256), mul = A*B, carry = sel[0].
- **Reset:** assert `rst` mid-cycle → all outputs are 0 immediately, with no clock edge needed; `busy`=0 and `rd_valid`=0 for every address.
- **Full sweep (SETTLE=2):** `start` in cycle 0 with A=0x58, B=0x06.
  - `alu_sel` steps 0→15, changing after cycles 3, 6, …, 45.
  - `done` is high in cycle 49 only.
  - rd_addr=0 → out 0x5E, mul 0x0210, carry 0, valid 1.
  - rd_addr=15 → out 0x6D, mul 0x0210, carry 1.
- **Start while busy:** `start`=1 with `a_in`=0xFF in cycle 10 → `alu_a` stays 0x58 and the sweep timing is unchanged.
- **Read during sweep:** rd_addr=3 in cycle 12 (capture cycle of opcode 3) → `rd_valid`=0 in cycle 13; rd_addr=3 in cycle 13 → `rd_valid`=1, out 0x61 in cycle 14.
- **Reset mid-sweep:** `rst` in cycle 20 → `busy`=0, `alu_sel`=0, all `valid`=0. A new `start` with A=0x10, B=0x02 then completes, with `done` 49 cycles after acceptance and entry 0 = 0x12.
- **Back-to-back:** `start` held high continuously → the second sweep is accepted in cycle 50, the valid mask is cleared at acceptance, and the second `done` is in cycle 99.
